// File: rtl/cordic_trig_16bit.sv
// cordic_trig_16bit
//   Iterative rotation-mode CORDIC producing cos/sin of a 16-bit binary angle
//   (0..65535 maps to 0..2*pi). One shift-add micro-rotation per clock.
//   A computation launches from IDLE on start, on any change of angle versus
//   the last captured angle, or when no valid result exists yet (after reset).
//
//   Ports:
//     clk     rising-edge clock
//     rst     synchronous active-high reset
//     start   force a recompute of the current angle (accepted while ready=1)
//     angle   unsigned binary angle, 16384 = 90 deg, 32768 = 180 deg
//     cosine  signed Q16.16 cos(angle), 0x00010000 = 1.0
//     sine    signed Q16.16 sin(angle)
//     done    one-cycle pulse in the cycle cosine/sine take a new value
//     ready   high while IDLE
//
//   Optional build macro CORDIC_CLAMP_EN: clamp each output to [-1.0, +1.0]
//   before it is registered. Latency is unchanged.
module cordic_trig_16bit #(
  parameter int unsigned ITERATIONS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        angle,
  output logic signed [31:0] cosine,
  output logic signed [31:0] sine,
  output logic               done,
  output logic               ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0]         LAST_ITER = 5'(ITERATIONS - 1);
  localparam logic signed [31:0] K_INIT    = 32'sd39797;
  localparam logic signed [31:0] ONE       = 32'sh0001_0000;

  state_t             state, state_nxt;
  logic               launch;
  logic [15:0]        last_angle;
  logic               valid;
  logic signed [31:0] x, y, z;
  logic [4:0]         iter;
  logic [1:0]         quad_r;

  logic [1:0]         quad;
  logic [15:0]        resid;
  logic signed [31:0] x_sh, y_sh, atan_i;
  logic signed [31:0] x_nxt, y_nxt, z_nxt;
  logic signed [31:0] map_c, map_s;

  // round(atan(2^-i) / (2*pi) * 2^32)
  function automatic logic signed [31:0] atan_tab(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_tab = 32'sh2000_0000;
      5'd1:    atan_tab = 32'sh12E4_051E;
      5'd2:    atan_tab = 32'sh09FB_385B;
      5'd3:    atan_tab = 32'sh0511_11D4;
      5'd4:    atan_tab = 32'sh028B_0D43;
      5'd5:    atan_tab = 32'sh0145_D7E1;
      5'd6:    atan_tab = 32'sh00A2_F61E;
      5'd7:    atan_tab = 32'sh0051_7C55;
      5'd8:    atan_tab = 32'sh0028_BE53;
      5'd9:    atan_tab = 32'sh0014_5F2F;
      5'd10:   atan_tab = 32'sh000A_2F98;
      5'd11:   atan_tab = 32'sh0005_17CC;
      5'd12:   atan_tab = 32'sh0002_8BE6;
      5'd13:   atan_tab = 32'sh0001_45F3;
      5'd14:   atan_tab = 32'sh0000_A2FA;
      5'd15:   atan_tab = 32'sh0000_517D;
      default: atan_tab = '0;
    endcase
  endfunction

`ifdef CORDIC_CLAMP_EN
  function automatic logic signed [31:0] clamp1(input logic signed [31:0] v);
    if (v > ONE)       clamp1 = ONE;
    else if (v < -ONE) clamp1 = -ONE;
    else               clamp1 = v;
  endfunction
`endif

  // Quadrant and residual. (angle + 8192) >> 14 is formed as angle[15:14]
  // plus the carry out of bit 13, so no unused sum bits are produced.
  always_comb begin
    quad  = angle[15:14] + 2'(angle[13]);
    resid = angle - {quad, 14'd0};
  end

  // Next-state and handshake.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start || (angle != last_angle) || !valid) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN:     if (iter == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One micro-rotation; direction follows the sign of the residual angle.
  always_comb begin
    x_sh   = x >>> iter;
    y_sh   = y >>> iter;
    atan_i = atan_tab(iter);
    if (z[31]) begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_i;
    end else begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_i;
    end
  end

  // Quadrant map back to the full circle.
  always_comb begin
    map_c = x;
    map_s = y;
    case (quad_r)
      2'd0: begin map_c = x;  map_s = y;  end
      2'd1: begin map_c = -y; map_s = x;  end
      2'd2: begin map_c = -x; map_s = -y; end
      2'd3: begin map_c = y;  map_s = -x; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cosine     <= '0;
      sine       <= '0;
      done       <= 1'b0;
      last_angle <= '0;
      valid      <= 1'b0;
      x          <= '0;
      y          <= '0;
      z          <= '0;
      iter       <= '0;
      quad_r     <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (launch) begin
        last_angle <= angle;
        quad_r     <= quad;
        x          <= K_INIT;
        y          <= '0;
        z          <= {resid, 16'h0000};
        iter       <= '0;
      end
      if (state == RUN) begin
        x    <= x_nxt;
        y    <= y_nxt;
        z    <= z_nxt;
        iter <= iter + 5'd1;
      end
      if (state == DONE) begin
`ifdef CORDIC_CLAMP_EN
        cosine <= clamp1(map_c);
        sine   <= clamp1(map_s);
`else
        cosine <= map_c;
        sine   <= map_s;
`endif
        done   <= 1'b1;
        valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cordic_trig_16bit.sv
// Self-checking bench for cordic_trig_16bit: stimulus pushes the expected
// cos/sin of each computation it triggers into a queue; a monitor pops and
// compares on every done pulse.
module tb_cordic_trig_16bit;

  typedef struct {
    int ang;
    int c;
    int s;
  } exp_t;

  localparam int TOL = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [15:0]        angle = '0;
  logic signed [31:0] cosine, sine;
  logic               done, ready;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  cordic_trig_16bit #(.ITERATIONS(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .angle (angle),
    .cosine(cosine),
    .sine  (sine),
    .done  (done),
    .ready (ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_near(input string name, input int act, input int req);
    int diff;
    checks++;
    diff = act - req;
    if (diff < -TOL || diff > TOL) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, req, TOL);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_angle(input int a, input int c, input int s);
    exp_t e;
    e.ang = a;
    e.c   = c;
    e.s   = s;
    sb.push_back(e);
  endtask

  // Monitor: compare every posted result against the queue head.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: cosine=%0d sine=%0d with no result pending", cosine, sine);
      end else begin
        e = sb.pop_front();
        check_near($sformatf("cos(%0d)", e.ang), cosine, e.c);
        check_near($sformatf("sin(%0d)", e.ang), sine, e.s);
`ifdef CORDIC_CLAMP_EN
        checks++;
        if (cosine > 32'sh10000 || cosine < -32'sh10000 || sine > 32'sh10000 || sine < -32'sh10000) begin
          errors++;
          $display("FAIL clamp(%0d): cosine=%0d sine=%0d exceed 65536", e.ang, cosine, sine);
        end
`endif
      end
    end
  end

  task automatic drain(input string name);
    check_eq({name, "_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    // Reset state
    tick(3);
    check_eq("rst_cosine", cosine, 0);
    check_eq("rst_sine", sine, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ready", ready, 1);

    // First IDLE after reset launches even with angle unchanged at 0
    expect_angle(0, 65536, 0);
    rst = 1'b0;
    tick(20);
    drain("angle0");
    check_eq("angle0_done_pulses", done_cnt, 1);
    check_eq("angle0_ready", ready, 1);

    // Static angle: no further launches
    tick(20);
    check_eq("static_no_relaunch", done_cnt, 1);

    // Directed vectors, one per quadrant plus wrap-around
    angle = 16'd16384; expect_angle(16384, 0, 65536);      tick(20); drain("a16384");
    angle = 16'd32768; expect_angle(32768, -65536, 0);     tick(20); drain("a32768");
    angle = 16'd8192;  expect_angle(8192, 46341, 46341);   tick(20); drain("a8192");
    angle = 16'd5461;  expect_angle(5461, 56756, 32766);   tick(20); drain("a5461");
    angle = 16'd49152; expect_angle(49152, 0, -65536);     tick(20); drain("a49152");
    angle = 16'd65535; expect_angle(65535, 65536, -6);     tick(20); drain("a65535");

    // start re-runs the same angle
    start = 1'b1; expect_angle(65535, 65536, -6);
    tick(1);
    start = 1'b0;
    tick(20);
    drain("start_rerun");

    // Angle change while busy: old result first, then relaunch
    angle = 16'd16384; expect_angle(16384, 0, 65536);
    tick(5);
    check_eq("busy_ready", ready, 0);
    angle = 16'd0; expect_angle(0, 65536, 0);
    tick(45);
    drain("busy_change");
    check_eq("busy_ready_after", ready, 1);

    // Reset during RUN aborts and clears outputs
    angle = 16'd32768;
    tick(6);
    check_eq("midrun_ready", ready, 0);
    rst = 1'b1;
    tick(1);
    check_eq("abort_cosine", cosine, 0);
    check_eq("abort_sine", sine, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_ready", ready, 1);
    expect_angle(32768, -65536, 0);
    rst = 1'b0;
    tick(20);
    drain("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
